// File: rtl/chess_clock_core_if.sv
// Bundle of control, configuration and display signals for chess_clock_core.
// Upstream logic drives through master; the countdown core sits on slave.
interface chess_clock_core_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int INC_W       = 6
);
  localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;

  // There is no valid/ready flow control on this bus. TICK, LOAD, START, SELECT
  // and STOP are single-cycle pulses that take effect on the clock edge where
  // they are high and CE is also high. The configuration fields only need to
  // be stable on the cycle LOAD is taken. Every output is held until the core
  // changes it.
  logic                     CE;
  logic                     TICK;
  logic                     LOAD;
  logic [6:0]               PRESET_MIN;
  logic [5:0]               PRESET_SEC;
  logic [INC_W-1:0]         INC_SEC;
  logic [1:0]               MODE;
  logic                     START;
  logic                     SELECT;
  logic                     STOP;
  logic [PW-1:0]            ACTIVE;
  logic                     RUNNING;
  logic                     TIMEOUT;
  logic [PW-1:0]            LOSER;
  logic [16*NUM_PLAYERS-1:0] BCD_OUT;
  logic [1:0]               dbg_state;

  modport master (
    output CE, TICK, LOAD, PRESET_MIN, PRESET_SEC, INC_SEC, MODE, START, SELECT, STOP,
    input  ACTIVE, RUNNING, TIMEOUT, LOSER, BCD_OUT, dbg_state
  );

  modport slave (
    input  CE, TICK, LOAD, PRESET_MIN, PRESET_SEC, INC_SEC, MODE, START, SELECT, STOP,
    output ACTIVE, RUNNING, TIMEOUT, LOSER, BCD_OUT, dbg_state
  );
endinterface

// File: rtl/chess_clock_core.sv
// N-player MM:SS countdown core: sudden-death, Fischer and Bronstein modes.
// Rotates the active player on SELECT, flags the first player to reach 00:00.
module chess_clock_core #(
  parameter int NUM_PLAYERS = 2,
  parameter int INC_W       = 6
) (
  input logic               CLK,
  input logic               CLR,
  chess_clock_core_if.slave bus
);
  localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam logic [PW-1:0] LAST = PW'(NUM_PLAYERS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_FLAG  = 2'd3
  } state_t;

  state_t           state_q, state_n;
  logic [6:0]       min_q [NUM_PLAYERS];
  logic [6:0]       min_n [NUM_PLAYERS];
  logic [5:0]       sec_q [NUM_PLAYERS];
  logic [5:0]       sec_n [NUM_PLAYERS];
  logic [PW-1:0]    active_q, active_n;
  logic [PW-1:0]    loser_q, loser_n;
  logic [1:0]       mode_q, mode_n;
  logic [INC_W-1:0] inc_q, inc_n;
  logic [INC_W-1:0] delay_q, delay_n;

  logic tick, sel, stop, start, load;
  logic fischer, bronstein;

  assign tick  = bus.CE & bus.TICK;
  assign sel   = bus.CE & bus.SELECT;
  assign stop  = bus.CE & bus.STOP;
  assign start = bus.CE & bus.START;
  assign load  = bus.CE & bus.LOAD;

  // Mode 11 falls through both decodes and behaves as sudden death.
  assign fischer   = (mode_q == 2'b01);
  assign bronstein = (mode_q == 2'b10);

  logic [6:0] cur_min, dec_min, base_min, inc_min;
  logic [5:0] cur_sec, dec_sec, base_sec, inc_sec;
  logic [7:0] sum_min, sum_sec;
  logic       tick_dec, flag_hit;
  logic [6:0] clamp_min;
  logic [5:0] clamp_sec;
  logic [INC_W-1:0] clamp_inc;

  // Datapath for the active channel: tick decrement feeds the Fischer adder so
  // a same-cycle TICK+SELECT credits the increment to the decremented value.
  always_comb begin
    cur_min  = min_q[active_q];
    cur_sec  = sec_q[active_q];
    dec_min  = cur_min;
    dec_sec  = cur_sec;
    if (cur_sec != 6'd0) begin
      dec_sec = cur_sec - 6'd1;
    end else if (cur_min != 7'd0) begin
      dec_min = cur_min - 7'd1;
      dec_sec = 6'd59;
    end
    tick_dec = tick && (delay_q == '0);
    flag_hit = tick_dec && (dec_min == 7'd0) && (dec_sec == 6'd0);
    base_min = tick_dec ? dec_min : cur_min;
    base_sec = tick_dec ? dec_sec : cur_sec;
    sum_sec  = {2'b00, base_sec} + 8'(inc_q);
    sum_min  = {1'b0, base_min};
    if (sum_sec >= 8'd60) begin
      sum_sec = sum_sec - 8'd60;
      sum_min = sum_min + 8'd1;
    end
    if (sum_min > 8'd99) begin
      inc_min = 7'd99;
      inc_sec = 6'd59;
    end else begin
      inc_min = sum_min[6:0];
      inc_sec = sum_sec[5:0];
    end
    clamp_min = (bus.PRESET_MIN > 7'd99) ? 7'd99 : bus.PRESET_MIN;
    clamp_sec = (bus.PRESET_SEC > 6'd59) ? 6'd59 : bus.PRESET_SEC;
    clamp_inc = (32'(bus.INC_SEC) > 32'd59) ? INC_W'(59) : bus.INC_SEC;
  end

  always_comb begin
    state_n  = state_q;
    active_n = active_q;
    loser_n  = loser_q;
    mode_n   = mode_q;
    inc_n    = inc_q;
    delay_n  = delay_q;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      min_n[i] = min_q[i];
      sec_n[i] = sec_q[i];
    end

    if (load && (state_q != S_RUN)) begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        min_n[i] = clamp_min;
        sec_n[i] = clamp_sec;
      end
      mode_n   = bus.MODE;
      inc_n    = clamp_inc;
      active_n = '0;
      loser_n  = '0;
      state_n  = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_n = S_RUN;
            delay_n = bronstein ? inc_q : '0;
          end
        end
        S_RUN: begin
          if (tick) begin
            if (delay_q != '0) begin
              delay_n = delay_q - INC_W'(1);
            end else begin
              min_n[active_q] = dec_min;
              sec_n[active_q] = dec_sec;
            end
          end
          // A flagging tick swallows any same-cycle SELECT and STOP.
          if (flag_hit) begin
            state_n = S_FLAG;
            loser_n = active_q;
          end else begin
            if (sel) begin
              if (fischer) begin
                min_n[active_q] = inc_min;
                sec_n[active_q] = inc_sec;
              end
              active_n = (active_q == LAST) ? '0 : active_q + PW'(1);
              if (bronstein) delay_n = inc_q;
            end
            if (stop) state_n = S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (stop) state_n = S_RUN;
        end
        default: begin
          state_n = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q  <= S_IDLE;
      active_q <= '0;
      loser_q  <= '0;
      mode_q   <= 2'b00;
      inc_q    <= '0;
      delay_q  <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        min_q[i] <= 7'd0;
        sec_q[i] <= 6'd0;
      end
    end else begin
      state_q  <= state_n;
      active_q <= active_n;
      loser_q  <= loser_n;
      mode_q   <= mode_n;
      inc_q    <= inc_n;
      delay_q  <= delay_n;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        min_q[i] <= min_n[i];
        sec_q[i] <= sec_n[i];
      end
    end
  end

  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

  always_comb begin
    bus.BCD_OUT = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      bus.BCD_OUT[16*i +: 16] = {to_bcd(min_q[i]), to_bcd({1'b0, sec_q[i]})};
    end
  end

  assign bus.ACTIVE    = active_q;
  assign bus.LOSER     = loser_q;
  assign bus.RUNNING   = (state_q == S_RUN);
  assign bus.TIMEOUT   = (state_q == S_FLAG);
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_chess_clock_core.sv
// Bench for chess_clock_core: a 2-player and a 3-player instance share one
// stimulus table; each row may carry an expected snapshot for either instance.
module tb_chess_clock_core;
  localparam int INC_W = 6;
  localparam logic [5:0] K_TICK  = 6'd1;
  localparam logic [5:0] K_SEL   = 6'd2;
  localparam logic [5:0] K_STOP  = 6'd4;
  localparam logic [5:0] K_START = 6'd8;
  localparam logic [5:0] K_LOAD  = 6'd16;
  localparam logic [5:0] K_NOCE  = 6'd32;

  logic CLK;
  logic CLR;

  chess_clock_core_if #(.NUM_PLAYERS(2), .INC_W(INC_W)) bus2 ();
  chess_clock_core_if #(.NUM_PLAYERS(3), .INC_W(INC_W)) bus3 ();

  chess_clock_core #(.NUM_PLAYERS(2), .INC_W(INC_W)) dut2 (.CLK(CLK), .CLR(CLR), .bus(bus2));
  chess_clock_core #(.NUM_PLAYERS(3), .INC_W(INC_W)) dut3 (.CLK(CLK), .CLR(CLR), .bus(bus3));

  assign bus3.CE         = bus2.CE;
  assign bus3.TICK       = bus2.TICK;
  assign bus3.LOAD       = bus2.LOAD;
  assign bus3.PRESET_MIN = bus2.PRESET_MIN;
  assign bus3.PRESET_SEC = bus2.PRESET_SEC;
  assign bus3.INC_SEC    = bus2.INC_SEC;
  assign bus3.MODE       = bus2.MODE;
  assign bus3.START      = bus2.START;
  assign bus3.SELECT     = bus2.SELECT;
  assign bus3.STOP       = bus2.STOP;

  // ---------------- clock ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic [5:0]  pulses;
    logic [6:0]  pmin;
    logic [5:0]  psec;
    logic [5:0]  inc;
    logic [1:0]  mode;
    bit          chk;
    bit          on3;
    logic [63:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [63:0] exp_q[$];
  string       name_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  function automatic logic [63:0] e2(bit t, bit r, bit l, bit a, logic [15:0] p1, logic [15:0] p0);
    return {28'd0, t, r, l, a, p1, p0};
  endfunction

  function automatic logic [63:0] e3(bit t, bit r, logic [1:0] l, logic [1:0] a,
                                     logic [15:0] p2, logic [15:0] p1, logic [15:0] p0);
    return {10'd0, t, r, l, a, p2, p1, p0};
  endfunction

  function automatic logic [63:0] snap(bit on3);
    if (on3) return {10'd0, bus3.TIMEOUT, bus3.RUNNING, bus3.LOSER, bus3.ACTIVE, bus3.BCD_OUT};
    return {28'd0, bus2.TIMEOUT, bus2.RUNNING, bus2.LOSER, bus2.ACTIVE, bus2.BCD_OUT};
  endfunction

  function automatic void add_l(string nm, logic [6:0] pmin, logic [5:0] psec, logic [5:0] inc,
                                logic [1:0] mode, bit chk, bit on3, logic [63:0] e);
    vec_t v;
    v.name = nm; v.pulses = K_LOAD; v.pmin = pmin; v.psec = psec; v.inc = inc; v.mode = mode;
    v.chk = chk; v.on3 = on3; v.exp = e;
    vecs.push_back(v);
  endfunction

  function automatic void add_p(string nm, logic [5:0] p, bit chk, bit on3, logic [63:0] e);
    vec_t v;
    v.name = nm; v.pulses = p; v.pmin = 7'd0; v.psec = 6'd0; v.inc = 6'd0; v.mode = 2'b00;
    v.chk = chk; v.on3 = on3; v.exp = e;
    vecs.push_back(v);
  endfunction

  function automatic void add_n(logic [5:0] p);
    add_p("", p, 1'b0, 1'b0, 64'd0);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus2.CE = 1'b1; bus2.TICK = 1'b0; bus2.SELECT = 1'b0; bus2.STOP = 1'b0;
    bus2.START = 1'b0; bus2.LOAD = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    bus2.CE         = ~v.pulses[5];
    bus2.LOAD       = v.pulses[4];
    bus2.START      = v.pulses[3];
    bus2.STOP       = v.pulses[2];
    bus2.SELECT     = v.pulses[1];
    bus2.TICK       = v.pulses[0];
    bus2.PRESET_MIN = v.pmin;
    bus2.PRESET_SEC = v.psec;
    bus2.INC_SEC    = v.inc;
    bus2.MODE       = v.mode;
  endtask

  // ---------------- scoreboard ----------------
  task automatic expect_val(string nm, logic [63:0] e);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic check(logic [63:0] act);
    logic [63:0] e;
    string nm;
    e  = exp_q.pop_front();
    nm = name_q.pop_front();
    n_checks++;
    if (act === e) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, e);
  endtask

  task automatic run_vecs();
    foreach (vecs[i]) begin
      drive(vecs[i]);
      if (vecs[i].chk) expect_val(vecs[i].name, vecs[i].exp);
      @(posedge CLK);
      #1;
      idle_inputs();
      if (vecs[i].chk) check(snap(vecs[i].on3));
    end
  endtask

  // ---------------- test ----------------
  initial begin
    CLR = 1'b1;
    idle_inputs();
    bus2.PRESET_MIN = 7'd0; bus2.PRESET_SEC = 6'd0; bus2.INC_SEC = 6'd0; bus2.MODE = 2'b00;

    // sudden death, 1:00 to flag
    add_l("sd_load", 7'd1, 6'd0, 6'd0, 2'b00, 1, 0, e2(0,0,0,0,16'h0100,16'h0100));
    add_p("sd_start", K_START, 1, 0, e2(0,1,0,0,16'h0100,16'h0100));
    add_p("sd_tick1", K_TICK, 1, 0, e2(0,1,0,0,16'h0100,16'h0059));
    for (int i = 2; i <= 58; i++) add_n(K_TICK);
    add_p("sd_tick59", K_TICK, 1, 0, e2(0,1,0,0,16'h0100,16'h0001));
    add_p("sd_tick60", K_TICK, 1, 0, e2(1,0,0,0,16'h0100,16'h0000));
    add_p("flag_hold", K_TICK | K_SEL | K_STOP | K_START, 1, 0, e2(1,0,0,0,16'h0100,16'h0000));
    add_l("flag_load", 7'd0, 6'd5, 6'd0, 2'b00, 1, 0, e2(0,0,0,0,16'h0005,16'h0005));

    // Fischer increment, carry and saturation
    add_l("f_load", 7'd0, 6'd10, 6'd5, 2'b01, 1, 0, e2(0,0,0,0,16'h0010,16'h0010));
    add_p("f_start", K_START, 1, 0, e2(0,1,0,0,16'h0010,16'h0010));
    add_n(K_TICK);
    add_n(K_TICK);
    add_p("f_tick3", K_TICK, 1, 0, e2(0,1,0,0,16'h0010,16'h0007));
    add_p("f_select", K_SEL, 1, 0, e2(0,1,0,1,16'h0010,16'h0012));
    add_p("f_stop", K_STOP, 1, 0, e2(0,0,0,1,16'h0010,16'h0012));
    add_l("f_load_sat", 7'd99, 6'd58, 6'd5, 2'b01, 1, 0, e2(0,0,0,0,16'h9958,16'h9958));
    add_n(K_START);
    add_p("f_sat", K_SEL, 1, 0, e2(0,1,0,1,16'h9958,16'h9959));
    add_p("f_tick_sel_sat", K_TICK | K_SEL, 1, 0, e2(0,1,0,0,16'h9959,16'h9959));
    add_n(K_STOP);
    add_l("f_load_carry", 7'd0, 6'd58, 6'd5, 2'b01, 1, 0, e2(0,0,0,0,16'h0058,16'h0058));
    add_n(K_START);
    add_p("f_carry", K_SEL, 1, 0, e2(0,1,0,1,16'h0058,16'h0103));
    add_p("ts_both", K_TICK | K_SEL, 1, 0, e2(0,1,0,0,16'h0102,16'h0103));
    add_n(K_STOP);
    add_l("clamp", 7'd120, 6'd63, 6'd0, 2'b00, 1, 0, e2(0,0,0,0,16'h9959,16'h9959));
    add_l("m3_load", 7'd0, 6'd10, 6'd5, 2'b11, 1, 0, e2(0,0,0,0,16'h0010,16'h0010));
    add_n(K_START);
    add_p("m3_select", K_SEL, 1, 0, e2(0,1,0,1,16'h0010,16'h0010));
    add_n(K_STOP);

    // Bronstein delay
    add_l("b_load", 7'd0, 6'd10, 6'd3, 2'b10, 1, 0, e2(0,0,0,0,16'h0010,16'h0010));
    add_p("b_start", K_START, 1, 0, e2(0,1,0,0,16'h0010,16'h0010));
    add_n(K_TICK);
    add_n(K_TICK);
    add_p("b_delay3", K_TICK, 1, 0, e2(0,1,0,0,16'h0010,16'h0010));
    add_n(K_TICK);
    add_p("b_tick5", K_TICK, 1, 0, e2(0,1,0,0,16'h0010,16'h0008));
    add_p("b_select", K_SEL, 1, 0, e2(0,1,0,1,16'h0010,16'h0008));
    add_n(K_TICK);
    add_n(K_TICK);
    add_p("b_p1_delay", K_TICK, 1, 0, e2(0,1,0,1,16'h0010,16'h0008));
    add_p("b_p1_tick", K_TICK, 1, 0, e2(0,1,0,1,16'h0009,16'h0008));

    // pause and input guards
    add_p("p_stop", K_STOP, 1, 0, e2(0,0,0,1,16'h0009,16'h0008));
    for (int i = 0; i < 9; i++) add_n(K_TICK);
    add_p("p_frozen", K_TICK | K_SEL, 1, 0, e2(0,0,0,1,16'h0009,16'h0008));
    add_p("p_start_ign", K_START, 1, 0, e2(0,0,0,1,16'h0009,16'h0008));
    add_p("p_resume", K_STOP, 1, 0, e2(0,1,0,1,16'h0009,16'h0008));
    add_p("p_tick", K_TICK, 1, 0, e2(0,1,0,1,16'h0008,16'h0008));
    add_l("r_load_ign", 7'd5, 6'd0, 6'd0, 2'b00, 1, 0, e2(0,1,0,1,16'h0008,16'h0008));
    add_p("ce_off", K_NOCE | K_TICK | K_SEL, 1, 0, e2(0,1,0,1,16'h0008,16'h0008));
    add_p("ce_off_stop", K_NOCE | K_STOP, 1, 0, e2(0,1,0,1,16'h0008,16'h0008));
    add_p("stop_tick", K_TICK | K_STOP, 1, 0, e2(0,0,0,1,16'h0007,16'h0008));

    // three players: rotation, same-cycle TICK+SELECT flag, flag beats STOP
    add_l("n3_load", 7'd2, 6'd0, 6'd0, 2'b00, 1, 1, e3(0,0,2'd0,2'd0,16'h0200,16'h0200,16'h0200));
    add_n(K_START);
    add_p("n3_sel1", K_SEL, 1, 1, e3(0,1,2'd0,2'd1,16'h0200,16'h0200,16'h0200));
    add_p("n3_sel2", K_SEL, 1, 1, e3(0,1,2'd0,2'd2,16'h0200,16'h0200,16'h0200));
    add_p("n3_sel3", K_SEL, 1, 1, e3(0,1,2'd0,2'd0,16'h0200,16'h0200,16'h0200));
    add_n(K_STOP);
    add_l("", 7'd0, 6'd2, 6'd0, 2'b00, 0, 0, 64'd0);
    add_n(K_START);
    add_p("n3_tick", K_TICK, 1, 1, e3(0,1,2'd0,2'd0,16'h0002,16'h0002,16'h0001));
    add_p("n3_flag_sel", K_TICK | K_SEL, 1, 1, e3(1,0,2'd0,2'd0,16'h0002,16'h0002,16'h0000));
    add_l("", 7'd0, 6'd1, 6'd0, 2'b00, 0, 0, 64'd0);
    add_n(K_START);
    add_p("n3_sel_p1", K_SEL, 1, 1, e3(0,1,2'd0,2'd1,16'h0001,16'h0001,16'h0001));
    add_p("n3_flag_p1", K_TICK | K_STOP, 1, 1, e3(1,0,2'd1,2'd1,16'h0001,16'h0000,16'h0001));

    // set up a running state for the asynchronous clear
    add_l("", 7'd0, 6'd30, 6'd0, 2'b00, 0, 0, 64'd0);
    add_n(K_START);
    add_n(K_SEL);
    add_p("pre_clr", K_TICK, 1, 0, e2(0,1,0,1,16'h0029,16'h0030));

    repeat (2) @(posedge CLK);
    #1;
    CLR = 1'b0;
    expect_val("reset2", e2(0,0,0,0,16'h0000,16'h0000));
    check(snap(1'b0));
    expect_val("reset3", e3(0,0,2'd0,2'd0,16'h0000,16'h0000,16'h0000));
    check(snap(1'b1));
    expect_val("reset_state2", 64'd0);
    check(64'(bus2.dbg_state));
    expect_val("reset_state3", 64'd0);
    check(64'(bus3.dbg_state));

    run_vecs();

    // clear between edges must act without a clock edge
    #2;
    CLR = 1'b1;
    #1;
    expect_val("async_clr2", e2(0,0,0,0,16'h0000,16'h0000));
    check(snap(1'b0));
    expect_val("async_clr3", e3(0,0,2'd0,2'd0,16'h0000,16'h0000,16'h0000));
    check(snap(1'b1));
    @(posedge CLK);
    #1;
    CLR = 1'b0;
    @(posedge CLK);
    #1;
    expect_val("post_clr", e2(0,0,0,0,16'h0000,16'h0000));
    check(snap(1'b0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/chess_clock_core.md
Name: chess_clock_core

Overview:
Parametrised N-player countdown core for the chess-clock design, replacing the fixed pair of timer channels and the separate switch and overflow logic with one block. It holds one MM:SS countdown per player and rotates the active player on each end-of-move pulse. It supports sudden-death, Fischer increment and Bronstein delay modes, and flags the first player whose time reaches 00:00. BCD outputs feed the existing decoder and seven-segment driver path; TICK comes from the prescaler.

Parameters:
NUM_PLAYERS, 2, number of countdown channels (2..8); localparam PW = max(1, clog2(NUM_PLAYERS)).
INC_W, 6, width of the increment/delay seconds field (value 0..59).

Ports:
CLK  in  1  system clock
CLR  in  1  asynchronous active-high reset
CE  in  1  global clock enable; 0 freezes all state and ignores all pulses
TICK  in  1  one-cycle 1 Hz enable pulse
LOAD  in  1  pulse: preset all channels, latch mode/increment
PRESET_MIN  in  7  binary minutes
PRESET_SEC  in  6  binary seconds
INC_SEC  in  INC_W  increment (Fischer) or delay (Bronstein) seconds
MODE  in  2  00 sudden death, 01 Fischer, 10 Bronstein, 11 = 00
START  in  1  pulse: IDLE->RUN
SELECT  in  1  pulse: active player ends move
STOP  in  1  pulse: toggle RUN/PAUSE
ACTIVE  out  PW  index of the player whose clock runs
RUNNING  out  1  high in RUN
TIMEOUT  out  1  high in FLAG
LOSER  out  PW  player that flagged
BCD_OUT  out  16*NUM_PLAYERS  per player {min_tens,min_units,sec_tens,sec_units}; player 0 at LSBs

Behaviour:
- Reset: all channels 00:00; ACTIVE=0, LOSER=0, RUNNING=0, TIMEOUT=0; cfg_mode=00, cfg_inc=0, delay_cnt=0; state IDLE.
- All outputs are registered. An event on clock edge k is visible after edge k. All pulse inputs are qualified by CE=1.
- Channel storage: binary min (7b, 0..99) and sec (6b, 0..59). BCD_OUT is derived combinationally from the registers (divide-by-10 lookup).
- States: IDLE, RUN, PAUSE, FLAG.
- LOAD is accepted in IDLE, PAUSE and FLAG, and ignored in RUN. On LOAD:
  - every channel <= {min(PRESET_MIN,99), min(PRESET_SEC,59)};
  - cfg_mode <= MODE; cfg_inc <= min(INC_SEC,59);
  - ACTIVE=0; TIMEOUT=0; LOSER=0; state IDLE.
- IDLE: START -> RUN. delay_cnt <= cfg_inc if Bronstein, else 0.
- RUN, TICK:
  - If delay_cnt>0, delay_cnt decrements and the channel is untouched.
  - Otherwise the active channel decrements: sec>0 gives sec-1; sec=0 with min>0 gives min-1, sec=59.
  - If the result is 00:00, or the channel was already 00:00: state FLAG, LOSER=ACTIVE, TIMEOUT=1.
- RUN, SELECT:
  - Fischer only: the outgoing channel gets +cfg_inc. If sec>=60, subtract 60 and min+1. The result saturates at 99:59.
  - ACTIVE <= (ACTIVE+1) mod NUM_PLAYERS.
  - delay_cnt <= cfg_inc if Bronstein.
- TICK and SELECT in the same cycle: the tick applies to the outgoing player first. If that tick flags, SELECT is discarded and ACTIVE is unchanged. Otherwise the increment is applied to the decremented value, then the player rotates.
- STOP in RUN -> PAUSE, evaluated after any same-cycle SELECT/TICK. If the same-cycle TICK flags, FLAG wins.
- PAUSE: TICK and SELECT are ignored; STOP -> RUN (delay_cnt is kept); LOAD -> IDLE.
- FLAG: all inputs except LOAD and CLR are ignored; channels hold their values.
- START outside IDLE is ignored. STOP in IDLE/FLAG is ignored.
- CLR mid-operation clears everything immediately, without waiting for a clock edge.
- Only the active channel ever decrements.

Test Plan:
1. NUM_PLAYERS=2, LOAD 1:00 mode 00, START, 60 TICKs -> player 0 passes 00:59 after tick 1; after tick 60 BCD_OUT[15:0]=0x0000, TIMEOUT=1, LOSER=0, RUNNING=0; further TICKs leave values unchanged.
2. Fischer: LOAD 0:10, INC 5, START, 3 TICKs, SELECT -> player0=00:12 (0x0012), ACTIVE=1, player1=00:10. LOAD 99:58 INC 5, START, SELECT -> player0=99:59.
3. Bronstein: LOAD 0:10, INC 3, START, 5 TICKs -> player0=00:08. SELECT, then 3 TICKs -> player1 still 00:10; 4th TICK -> 00:09.
4. NUM_PLAYERS=3: LOAD 2:00, START, SELECT x3 -> ACTIVE 1,2,0. TICK and SELECT in the same cycle with player0 at 00:01 -> TIMEOUT=1, LOSER=0, ACTIVE stays 0.
5. Pause/guards:
   - STOP in RUN, 10 TICKs -> values frozen, RUNNING=0; STOP -> RUN resumes.
   - LOAD in RUN -> ignored.
   - CE=0 with TICK/SELECT -> no change.
6. Reset: CLR asserted mid-RUN between clock edges -> all BCD_OUT=0, ACTIVE=0, TIMEOUT=0, RUNNING=0 with no clock edge required.
